// File: rtl/switch_pkg.sv
// Shared constants and types for the switch host port and its queues.
// Frame layout is {dst, src, payload}, with dst in the most significant bits.
package switch_pkg;

    localparam int WIDTH     = 128;
    localparam int MAC_W     = 48;
    localparam int PAYLOAD_W = 32;

    localparam int DST_LSB = 80;
    localparam int SRC_LSB = 32;

    localparam logic [MAC_W-1:0] BCAST_MAC = 48'hFFFF_FFFF_FFFF;

    typedef struct packed {
        logic [MAC_W-1:0]     dst;
        logic [MAC_W-1:0]     src;
        logic [PAYLOAD_W-1:0] payload;
    } frame_t;

    typedef struct packed {
        logic [MAC_W-1:0]     dst;
        logic [PAYLOAD_W-1:0] payload;
    } desc_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } tx_state_e;

endpackage

// File: rtl/switch_sync_fifo.sv
// Synchronous FIFO with registered (block-RAM style) read and occupancy level.
// An entry written at one edge becomes visible to the reader one edge later.
module switch_sync_fifo #(
    parameter int DATA_W = 80,
    parameter int DEPTH  = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [DATA_W-1:0]        push_data,
    input  logic                     pop,
    output logic [DATA_W-1:0]        pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_data_reg;
    logic [AW:0]       wr_ptr_reg;
    logic [AW:0]       rd_ptr_reg;
    logic [AW:0]       vis_wr_ptr_reg;
    logic [AW:0]       rd_ptr_next;
    logic              push_en;
    logic              pop_en;

    assign level       = wr_ptr_reg - rd_ptr_reg;
    assign full        = (level == (AW+1)'(DEPTH));
    // Emptiness uses the lagged write pointer so the registered read has caught up.
    assign empty       = (vis_wr_ptr_reg == rd_ptr_reg);
    assign push_en     = push && !full;
    assign pop_en      = pop && !empty;
    assign rd_ptr_next = pop_en ? (rd_ptr_reg + PTR_ONE) : rd_ptr_reg;
    assign pop_data    = rd_data_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            vis_wr_ptr_reg <= '0;
        end else begin
            if (push_en) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            end
            rd_ptr_reg     <= rd_ptr_next;
            vis_wr_ptr_reg <= wr_ptr_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (push_en) begin
            mem[wr_ptr_reg[AW-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        rd_data_reg <= mem[rd_ptr_next[AW-1:0]];
    end

endmodule

// File: rtl/switch_port_tx.sv
// Host-side frame transmitter: queues descriptors, prepends the station MAC and
// launches one-cycle frame strobes into a switch port with a fixed inter-frame gap.
module switch_port_tx #(
    parameter int WIDTH      = 128,
    parameter int MAC_W      = 48,
    parameter int PAYLOAD_W  = 32,
    parameter int FIFO_DEPTH = 16,
    parameter int IFG        = 2,
    parameter int CNT_W      = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [MAC_W-1:0]              src_mac,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [MAC_W-1:0]              in_dst,
    input  logic [PAYLOAD_W-1:0]          in_payload,
    input  logic                          tx_pause,
    output logic                          tx_valid,
    output logic [WIDTH-1:0]              tx_data,
    output logic [CNT_W-1:0]              tx_frame_cnt,
    output logic [CNT_W-1:0]              tx_bcast_cnt,
    output logic [CNT_W-1:0]              tx_drop_cnt,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          busy
);

    import switch_pkg::*;

    localparam int GAP_W = (IFG > 1) ? $clog2(IFG) : 1;
    localparam logic [GAP_W-1:0] GAP_ONE  = 1;
    localparam logic [GAP_W-1:0] GAP_INIT = GAP_W'((IFG > 0) ? (IFG - 1) : 0);
    localparam logic [CNT_W-1:0] CNT_ONE  = 1;

    tx_state_e               state_reg;
    tx_state_e               state_next;
    logic [GAP_W-1:0]        gap_reg;
    logic [GAP_W-1:0]        gap_next;
    logic                    ready_en_reg;
    frame_t                  frame_reg;
    logic [CNT_W-1:0]        frame_cnt_reg;
    logic [CNT_W-1:0]        bcast_cnt_reg;
    logic [CNT_W-1:0]        drop_cnt_reg;

    desc_t                   push_desc;
    desc_t                   head;
    logic [$bits(desc_t)-1:0] head_bits;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    eval_slot;
    logic                    launch;
    logic                    drop;
    logic                    xmit;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : (v + CNT_ONE);
    endfunction

    assign push_desc = '{dst: in_dst, payload: in_payload};
    assign head      = head_bits;
    // in_ready is held low until the first clock after reset release.
    assign in_ready  = ready_en_reg && !fifo_full;

    switch_sync_fifo #(
        .DATA_W ($bits(desc_t)),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (in_valid && in_ready),
        .push_data (push_desc),
        .pop       (launch),
        .pop_data  (head_bits),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            gap_reg   <= '0;
        end else begin
            state_reg <= state_next;
            gap_reg   <= gap_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        gap_next   = gap_reg;
        eval_slot  = 1'b0;
        case (state_reg)
            IDLE:    eval_slot = 1'b1;
            SEND:    eval_slot = (IFG == 0);
            GAP:     eval_slot = (gap_reg == '0);
            default: eval_slot = 1'b0;
        endcase
        launch = eval_slot && !fifo_empty && !tx_pause;
        // A self-addressed head is consumed without a strobe or a gap.
        drop   = launch && (head.dst == src_mac);
        xmit   = launch && !drop;
        case (state_reg)
            IDLE: begin
                if (xmit) state_next = SEND;
            end
            SEND: begin
                if (IFG == 0) begin
                    state_next = xmit ? SEND : IDLE;
                end else begin
                    state_next = GAP;
                    gap_next   = GAP_INIT;
                end
            end
            GAP: begin
                if (gap_reg == '0) begin
                    state_next = xmit ? SEND : IDLE;
                end else begin
                    gap_next = gap_reg - GAP_ONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        tx_valid = (state_reg == SEND);
        tx_data  = tx_valid ? frame_reg : '0;
        busy     = (state_reg != IDLE) || (fifo_level != '0);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ready_en_reg  <= 1'b0;
            frame_reg     <= '0;
            frame_cnt_reg <= '0;
            bcast_cnt_reg <= '0;
            drop_cnt_reg  <= '0;
        end else begin
            ready_en_reg <= 1'b1;
            if (xmit) begin
                frame_reg     <= '{dst: head.dst, src: src_mac, payload: head.payload};
                frame_cnt_reg <= sat_inc(frame_cnt_reg);
                if (head.dst == BCAST_MAC) begin
                    bcast_cnt_reg <= sat_inc(bcast_cnt_reg);
                end
            end
            if (drop) begin
                drop_cnt_reg <= sat_inc(drop_cnt_reg);
            end
        end
    end

    assign tx_frame_cnt = frame_cnt_reg;
    assign tx_bcast_cnt = bcast_cnt_reg;
    assign tx_drop_cnt  = drop_cnt_reg;

endmodule

// File: tb/tb_switch_port_tx.sv
// Scoreboard bench for switch_port_tx: port A uses IFG=2, port B uses IFG=0.
// Stimulus queues expected frames; a negedge monitor pops and compares them.
module tb_switch_port_tx;

    localparam logic [47:0] SRC = 48'h112233445566;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    logic [47:0]  src_mac;

    logic         a_rst, a_in_valid, a_in_ready, a_tx_pause, a_tx_valid, a_busy;
    logic [47:0]  a_in_dst;
    logic [31:0]  a_in_payload;
    logic [127:0] a_tx_data;
    logic [15:0]  a_frame_cnt, a_bcast_cnt, a_drop_cnt;
    logic [4:0]   a_level;

    logic         b_rst, b_in_valid, b_in_ready, b_tx_pause, b_tx_valid, b_busy;
    logic [47:0]  b_in_dst;
    logic [31:0]  b_in_payload;
    logic [127:0] b_tx_data;
    logic [15:0]  b_frame_cnt, b_bcast_cnt, b_drop_cnt;
    logic [4:0]   b_level;

    logic [127:0] exp_a[$];
    logic [127:0] exp_b[$];
    int           pul_a[$];
    int           pul_b[$];

    switch_port_tx #(.IFG(2)) dut_a (
        .clk(clk), .reset(a_rst), .src_mac(src_mac),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_dst(a_in_dst), .in_payload(a_in_payload),
        .tx_pause(a_tx_pause), .tx_valid(a_tx_valid), .tx_data(a_tx_data),
        .tx_frame_cnt(a_frame_cnt), .tx_bcast_cnt(a_bcast_cnt), .tx_drop_cnt(a_drop_cnt),
        .fifo_level(a_level), .busy(a_busy)
    );

    switch_port_tx #(.IFG(0)) dut_b (
        .clk(clk), .reset(b_rst), .src_mac(src_mac),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_dst(b_in_dst), .in_payload(b_in_payload),
        .tx_pause(b_tx_pause), .tx_valid(b_tx_valid), .tx_data(b_tx_data),
        .tx_frame_cnt(b_frame_cnt), .tx_bcast_cnt(b_bcast_cnt), .tx_drop_cnt(b_drop_cnt),
        .fifo_level(b_level), .busy(b_busy)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (a_tx_valid) begin
            pul_a.push_back(cyc);
            $display("[%0d] port A tx %h", cyc, a_tx_data);
            if (exp_a.size() == 0) begin
                total++;
                bad++;
                $display("FAIL a_unexpected_frame: got %h, required no frame", a_tx_data);
            end else begin
                chk("a_frame", a_tx_data, exp_a.pop_front());
            end
        end else begin
            chk("a_idle_data", a_tx_data, 128'h0);
        end
        if (b_tx_valid) begin
            pul_b.push_back(cyc);
            $display("[%0d] port B tx %h", cyc, b_tx_data);
            if (exp_b.size() == 0) begin
                total++;
                bad++;
                $display("FAIL b_unexpected_frame: got %h, required no frame", b_tx_data);
            end else begin
                chk("b_frame", b_tx_data, exp_b.pop_front());
            end
        end else begin
            chk("b_idle_data", b_tx_data, 128'h0);
        end
    end

    // Called at a negedge; drives for one posedge and returns at the next negedge.
    task automatic push(input bit sel, input logic [47:0] d, input logic [31:0] p,
                        output bit acc, output int ecyc);
        if (!sel) begin
            a_in_dst = d; a_in_payload = p; a_in_valid = 1'b1; acc = a_in_ready;
        end else begin
            b_in_dst = d; b_in_payload = p; b_in_valid = 1'b1; acc = b_in_ready;
        end
        @(posedge clk);
        @(negedge clk);
        ecyc = cyc;
        a_in_valid = 1'b0;
        b_in_valid = 1'b0;
        $display("[%0d] push port %0d dst=%h payload=%h accepted=%0d", ecyc, sel, d, p, acc);
    endtask

    task automatic wait_pulses(input bit sel, input int n, input int budget, input string name);
        int k = 0;
        while (((sel ? pul_b.size() : pul_a.size()) < n) && (k < budget)) begin
            @(negedge clk);
            k++;
        end
        chk(name, sel ? pul_b.size() : pul_a.size(), n);
    endtask

    task automatic reset_dut(input bit sel);
        if (!sel) begin a_rst = 1'b0; exp_a.delete(); pul_a.delete(); end
        else      begin b_rst = 1'b0; exp_b.delete(); pul_b.delete(); end
        repeat (2) @(negedge clk);
        a_rst = 1'b1;
        b_rst = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        int e, e2;
        src_mac = SRC;
        a_rst = 1'b0; a_in_valid = 1'b0; a_in_dst = '0; a_in_payload = '0; a_tx_pause = 1'b0;
        b_rst = 1'b0; b_in_valid = 1'b0; b_in_dst = '0; b_in_payload = '0; b_tx_pause = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_in_ready", a_in_ready, 0);
        chk("rst_tx_valid", a_tx_valid, 0);
        chk("rst_level", a_level, 0);
        chk("rst_frame_cnt", a_frame_cnt, 0);
        chk("rst_busy", a_busy, 0);
        a_rst = 1'b1;
        b_rst = 1'b1;
        #1;
        chk("ready_low_before_clk", a_in_ready, 0);
        @(negedge clk);
        chk("ready_after_release", a_in_ready, 1);

        // Unicast
        exp_a.push_back(128'hAABBCCDDEEFF112233445566DEADBEEF);
        push(0, 48'hAABBCCDDEEFF, 32'hDEADBEEF, acc, e);
        chk("uni_accept", acc, 1);
        wait_pulses(0, 1, 20, "uni_pulse");
        chk("uni_latency", (pul_a.size() > 0) ? (pul_a[0] - e) : -1, 2);
        repeat (8) @(negedge clk);
        chk("uni_single_pulse", pul_a.size(), 1);
        chk("uni_frame_cnt", a_frame_cnt, 1);
        chk("uni_bcast_cnt", a_bcast_cnt, 0);

        // Broadcast
        reset_dut(0);
        exp_a.push_back(128'hFFFFFFFFFFFF11223344556600000000);
        push(0, 48'hFFFFFFFFFFFF, 32'h0, acc, e);
        wait_pulses(0, 1, 20, "bc_pulse");
        repeat (4) @(negedge clk);
        chk("bc_bcast_cnt", a_bcast_cnt, 1);
        chk("bc_frame_cnt", a_frame_cnt, 1);

        // Self-addressed drop followed by a valid descriptor
        reset_dut(0);
        push(0, SRC, 32'h1, acc, e);
        exp_a.push_back(128'h0A0B0C0D0E0F11223344556600000002);
        push(0, 48'h0A0B0C0D0E0F, 32'h2, acc, e2);
        wait_pulses(0, 1, 20, "drop_pulse");
        chk("drop_timing", (pul_a.size() > 0) ? (pul_a[0] - e) : -1, 3);
        repeat (6) @(negedge clk);
        chk("drop_cnt", a_drop_cnt, 1);
        chk("drop_frame_cnt", a_frame_cnt, 1);
        chk("drop_single_pulse", pul_a.size(), 1);

        // Fill under pause, then drain with IFG spacing
        reset_dut(0);
        a_tx_pause = 1'b1;
        for (int i = 0; i < 17; i++) begin
            push(0, 48'h020000000000 + 48'(i), 32'h10000000 + 32'(i), acc, e);
            chk("full_accept", acc, (i < 16));
            if (i < 16) exp_a.push_back({48'h020000000000 + 48'(i), SRC, 32'h10000000 + 32'(i)});
        end
        chk("full_level", a_level, 16);
        chk("full_in_ready", a_in_ready, 0);
        chk("full_busy", a_busy, 1);
        repeat (3) @(negedge clk);
        chk("pause_hold_level", a_level, 16);
        chk("pause_no_pulse", pul_a.size(), 0);
        a_tx_pause = 1'b0;
        wait_pulses(0, 16, 120, "burst_pulses");
        for (int i = 1; i < pul_a.size(); i++) begin
            chk("burst_gap", pul_a[i] - pul_a[i-1], 3);
        end
        repeat (5) @(negedge clk);
        chk("drain_level", a_level, 0);
        chk("drain_busy", a_busy, 0);
        chk("drain_frame_cnt", a_frame_cnt, 16);

        // Asynchronous reset during a gap with entries queued
        reset_dut(0);
        a_tx_pause = 1'b1;
        for (int i = 0; i < 6; i++) begin
            exp_a.push_back({48'h030000000000 + 48'(i), SRC, 32'h20000000 + 32'(i)});
            push(0, 48'h030000000000 + 48'(i), 32'h20000000 + 32'(i), acc, e);
        end
        a_tx_pause = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("gap_pre_level", a_level, 5);
        chk("gap_pre_frame_cnt", a_frame_cnt, 1);
        #2;
        a_rst = 1'b0;
        #1;
        exp_a.delete();
        pul_a.delete();
        chk("async_tx_valid", a_tx_valid, 0);
        chk("async_tx_data", a_tx_data, 128'h0);
        chk("async_frame_cnt", a_frame_cnt, 0);
        chk("async_level", a_level, 0);
        @(negedge clk);
        a_rst = 1'b1;
        repeat (30) @(negedge clk);
        chk("no_stale_frames", pul_a.size(), 0);
        exp_a.push_back(128'h0405060708091122334455660000ABCD);
        push(0, 48'h040506070809, 32'h0000ABCD, acc, e);
        wait_pulses(0, 1, 20, "post_reset_pulse");
        chk("post_reset_scoreboard", exp_a.size(), 0);

        // IFG=0 back-to-back burst
        b_tx_pause = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_b.push_back({48'h050000000000 + 48'(i), SRC, 32'h30000000 + 32'(i)});
            push(1, 48'h050000000000 + 48'(i), 32'h30000000 + 32'(i), acc, e);
        end
        b_tx_pause = 1'b0;
        wait_pulses(1, 4, 20, "b2b_pulses");
        for (int i = 1; i < pul_b.size(); i++) begin
            chk("b2b_gap", pul_b[i] - pul_b[i-1], 1);
        end

        // Pause asserted during the burst: current frame completes, nothing after
        pul_b.delete();
        b_tx_pause = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_b.push_back({48'h060000000000 + 48'(i), SRC, 32'h40000000 + 32'(i)});
            push(1, 48'h060000000000 + 48'(i), 32'h40000000 + 32'(i), acc, e);
        end
        b_tx_pause = 1'b0;
        @(negedge clk);
        b_tx_pause = 1'b1;
        repeat (10) @(negedge clk);
        chk("midpause_pulses", pul_b.size(), 1);
        chk("midpause_level", b_level, 3);
        chk("midpause_pending", exp_b.size(), 3);
        chk("midpause_frame_cnt", b_frame_cnt, 5);
        b_tx_pause = 1'b0;
        reset_dut(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
